// File: rtl/oci_trace_pkg.sv
// Shared definitions for the OCI direct-compressed-trace capture block.
//   - state_e    : capture phase (IDLE, RUN, DRAIN, DONE)
//   - DEF_*      : default geometry of one DCT record
//   - rec_w()    : width of one stored record {count, buffer}
package oci_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int DEF_ENTRY_W     = 2;
  localparam int DEF_MAX_ENTRIES = 15;
  localparam int DEF_CNT_W       = 4;

  // Stored record: entry count in the MSBs, masked entry buffer below it.
  function automatic int rec_w(input int entry_w, input int max_entries, input int cnt_w);
    return cnt_w + entry_w * max_entries;
  endfunction

endpackage

// File: rtl/oci_trace_fifo.sv
// Synchronous show-ahead FIFO.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   push/wdata : write request; accepted when not full, or when full and a pop
//                happens in the same cycle
//   pop        : read request; ignored while empty
//   rdata      : head record, valid whenever empty=0; driven to zero when empty
//   full/empty : occupancy flags decoded from the level register
//   level      : number of records held
module oci_trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             push_ok, pop_ok;

  assign empty = (level_q == '0);
  assign full  = (level_q == LW'(DEPTH));
  assign level = level_q;
  // Head is read straight from storage, so rdata has no path from pop.
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    pop_ok   = pop && !empty;
    // A full FIFO still takes a write when the head leaves this same cycle.
    push_ok  = push && (!full || pop_ok);
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    level_d  = level_q + LW'(push_ok) - LW'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: contents are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/cpu_qsys_oci_dct_capture.sv
// Captures DCT records from on-chip instrumentation into a FIFO and tracks
// the end-of-test phases so every record can be drained before done.
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   enable              : arms capture (looked at only in IDLE)
//   dct_valid/buffer/count : incoming record; entries >= count are zeroed
//   drop_empty          : discard count==0 records
//   test_ending         : start draining
//   test_has_ended      : run finished (sticky once seen)
//   rd_ready/rd_valid/rd_data : valid/ready read port
//   level               : records held
//   overflow, bad_count : sticky error flags
//   drop_cnt            : saturating count of records lost to a full FIFO
//   done                : capture finished and FIFO drained
//   state_dbg           : current phase, encoded as oci_trace_pkg::state_e
// Read handshake: a record moves when rd_valid and rd_ready are both high on
// a rising edge; rd_data holds steady while rd_valid=1 and rd_ready=0.
module cpu_qsys_oci_dct_capture
  import oci_trace_pkg::*;
#(
  parameter int ENTRY_W     = DEF_ENTRY_W,
  parameter int MAX_ENTRIES = DEF_MAX_ENTRIES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int DEPTH       = 16,
  localparam int BUF_W = ENTRY_W * MAX_ENTRIES,
  localparam int REC_W = rec_w(ENTRY_W, MAX_ENTRIES, CNT_W),
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             dct_valid,
  input  logic [BUF_W-1:0] dct_buffer,
  input  logic [CNT_W-1:0] dct_count,
  input  logic             drop_empty,
  input  logic             test_ending,
  input  logic             test_has_ended,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [REC_W-1:0] rd_data,
  output logic [LVL_W-1:0] level,
  output logic             overflow,
  output logic             bad_count,
  output logic [15:0]      drop_cnt,
  output logic             done,
  output logic [1:0]       state_dbg
);

  state_e      state_q, state_d;
  logic        ended_q, ended_d;
  logic        overflow_q, overflow_d;
  logic        bad_q, bad_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        done_q, done_d;

  logic [BUF_W-1:0] masked_buf;
  logic             cnt_bad, want_push, pop_fire, lost;
  logic             fifo_full, fifo_empty;
  logic [LVL_W-1:0] fifo_level;

  oci_trace_fifo #(.WIDTH(REC_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (want_push),
    .wdata ({dct_count, masked_buf}),
    .pop   (rd_ready),
    .rdata (rd_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Entries past the reported count are stale; store them as zero.
  always_comb begin
    masked_buf = '0;
    for (int i = 0; i < MAX_ENTRIES; i++) begin
      if (i < int'(dct_count)) masked_buf[i*ENTRY_W +: ENTRY_W] = dct_buffer[i*ENTRY_W +: ENTRY_W];
    end
  end

  assign cnt_bad   = int'(dct_count) > MAX_ENTRIES;
  assign want_push = (state_q == ST_RUN) && dct_valid && !cnt_bad &&
                     !(drop_empty && (dct_count == '0));
  assign pop_fire  = !fifo_empty && rd_ready;
  assign lost      = want_push && fifo_full && !pop_fire;

  always_comb begin
    state_d    = state_q;
    ended_d    = ended_q;
    overflow_d = overflow_q | lost;
    bad_d      = bad_q | ((state_q == ST_RUN) && dct_valid && cnt_bad);
    drop_cnt_d = drop_cnt_q;
    if (lost && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
    if (((state_q == ST_RUN) || (state_q == ST_DRAIN)) && test_has_ended) ended_d = 1'b1;

    case (state_q)
      ST_IDLE:  if (enable) state_d = ST_RUN;
      ST_RUN:   if (test_ending || test_has_ended) state_d = ST_DRAIN;
      // No pushes happen in DRAIN, so the post-edge level is level - pop.
      ST_DRAIN: if (ended_d && (fifo_level == LVL_W'(pop_fire))) state_d = ST_DONE;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase

    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ended_q    <= 1'b0;
      overflow_q <= 1'b0;
      bad_q      <= 1'b0;
      drop_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ended_q    <= ended_d;
      overflow_q <= overflow_d;
      bad_q      <= bad_d;
      drop_cnt_q <= drop_cnt_d;
      done_q     <= done_d;
    end
  end

  assign rd_valid  = !fifo_empty;
  assign level     = fifo_level;
  assign overflow  = overflow_q;
  assign bad_count = bad_q;
  assign drop_cnt  = drop_cnt_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_cpu_qsys_oci_dct_capture.sv
module tb_cpu_qsys_oci_dct_capture;
  import oci_trace_pkg::*;

  localparam int ENTRY_W = 2;
  localparam int MAXE    = 15;
  localparam int CNT_W   = 4;
  localparam int DEPTH   = 16;
  localparam int BUF_W   = ENTRY_W * MAXE;
  localparam int REC_W   = CNT_W + BUF_W;
  localparam int LVL_W   = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, enable, dct_valid, drop_empty, test_ending, test_has_ended, rd_ready;
  logic [BUF_W-1:0] dct_buffer;
  logic [CNT_W-1:0] dct_count;
  logic             rd_valid, overflow, bad_count, done;
  logic [REC_W-1:0] rd_data;
  logic [LVL_W-1:0] level;
  logic [15:0]      drop_cnt;
  logic [1:0]       state_dbg;

  cpu_qsys_oci_dct_capture dut (
    .clk(clk), .reset(reset), .enable(enable), .dct_valid(dct_valid),
    .dct_buffer(dct_buffer), .dct_count(dct_count), .drop_empty(drop_empty),
    .test_ending(test_ending), .test_has_ended(test_has_ended), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .level(level), .overflow(overflow),
    .bad_count(bad_count), .drop_cnt(drop_cnt), .done(done), .state_dbg(state_dbg)
  );

  // Second build with 14 entries per buffer, so count 15 is out of range.
  logic        b_enable, b_valid;
  logic [27:0] b_buffer;
  logic [3:0]  b_count;
  logic        b_rd_valid, b_overflow, b_bad, b_done;
  logic [31:0] b_rd_data;
  logic [4:0]  b_level;
  logic [15:0] b_drop;
  logic [1:0]  b_state;

  cpu_qsys_oci_dct_capture #(.MAX_ENTRIES(14)) u14 (
    .clk(clk), .reset(reset), .enable(b_enable), .dct_valid(b_valid),
    .dct_buffer(b_buffer), .dct_count(b_count), .drop_empty(1'b0),
    .test_ending(1'b0), .test_has_ended(1'b0), .rd_ready(1'b0),
    .rd_valid(b_rd_valid), .rd_data(b_rd_data), .level(b_level), .overflow(b_overflow),
    .bad_count(b_bad), .drop_cnt(b_drop), .done(b_done), .state_dbg(b_state)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [REC_W-1:0] exp_q[$];
  state_e m_state;
  bit     m_ovf, m_bad, m_ended;
  int     m_drop;
  int     n_vec = 0;
  int     n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [REC_W-1:0] make_rec(input logic [CNT_W-1:0] c, input logic [BUF_W-1:0] b);
    logic [63:0] mask;
    mask = (64'd1 << (ENTRY_W * int'(c))) - 64'd1;
    return {c, b & mask[BUF_W-1:0]};
  endfunction

  // Advance the model by one clock edge using the inputs now applied.
  task automatic model_edge();
    bit pop, full;
    if (reset) begin
      exp_q.delete();
      m_state = ST_IDLE; m_ovf = 0; m_bad = 0; m_ended = 0; m_drop = 0;
      return;
    end
    full = (exp_q.size() == DEPTH);
    pop  = (exp_q.size() != 0) && rd_ready;
    if (pop) void'(exp_q.pop_front());
    if (m_state == ST_RUN && dct_valid) begin
      if (int'(dct_count) > MAXE) m_bad = 1;
      else if (!(drop_empty && dct_count == 0)) begin
        if (full && !pop) begin
          m_ovf = 1;
          if (m_drop < 65535) m_drop++;
        end else exp_q.push_back(make_rec(dct_count, dct_buffer));
      end
    end
    if ((m_state == ST_RUN || m_state == ST_DRAIN) && test_has_ended) m_ended = 1;
    case (m_state)
      ST_IDLE:  if (enable) m_state = ST_RUN;
      ST_RUN:   if (test_ending || test_has_ended) m_state = ST_DRAIN;
      ST_DRAIN: if (m_ended && exp_q.size() == 0) m_state = ST_DONE;
      default:  ;
    endcase
  endtask

  task automatic check_all();
    chk("rd_valid",  64'(rd_valid),  64'(exp_q.size() != 0));
    chk("rd_data",   64'(rd_data),   (exp_q.size() != 0) ? 64'(exp_q[0]) : 64'd0);
    chk("level",     64'(level),     64'(exp_q.size()));
    chk("overflow",  64'(overflow),  64'(m_ovf));
    chk("bad_count", 64'(bad_count), 64'(m_bad));
    chk("drop_cnt",  64'(drop_cnt),  64'(m_drop));
    chk("done",      64'(done),      64'(m_state == ST_DONE));
    chk("state",     64'(state_dbg), 64'(m_state));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic push_rec(input logic [CNT_W-1:0] c, input logic [BUF_W-1:0] b);
    dct_valid = 1'b1; dct_count = c; dct_buffer = b;
    step();
    dct_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    rd_ready = 1'b1;
    for (int k = 0; k < budget && exp_q.size() != 0; k++) step();
    chk("drain_empty", 64'(level), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [BUF_W-1:0] b1;

  initial begin
    reset = 1; enable = 0; dct_valid = 0; dct_buffer = '0; dct_count = '0;
    drop_empty = 0; test_ending = 0; test_has_ended = 0; rd_ready = 0;
    b_enable = 0; b_valid = 0; b_buffer = '0; b_count = '0;
    step(); step();
    reset = 0;
    chk("rst_state", 64'(state_dbg), 64'(ST_IDLE));

    // Arm both builds.
    enable = 1; b_enable = 1;
    step();
    enable = 0; b_enable = 0;

    // 14-entry build: count 15 is rejected, count 14 accepted.
    b_valid = 1; b_count = 4'd15; b_buffer = 28'(42'($urandom()));
    step();
    chk("b14_bad", 64'(b_bad), 64'd1);
    chk("b14_lvl0", 64'(b_level), 64'd0);
    chk("b14_drop", 64'(b_drop), 64'd0);
    b_count = 4'd14;
    step();
    b_valid = 0;
    chk("b14_lvl1", 64'(b_level), 64'd1);

    // Counts 15, 1, 0 with immediate reads; count 15 is in range here.
    rd_ready = 1;
    push_rec(4'd15, BUF_W'($urandom()));
    b1 = BUF_W'($urandom()) | BUF_W'(3);
    push_rec(4'd1, b1);
    chk("cnt1_rec", 64'(rd_data), {30'd0, 4'd1, 28'd0, b1[1:0]});
    push_rec(4'd0, BUF_W'($urandom()));
    step();
    chk("bad_15ok", 64'(bad_count), 64'd0);

    // drop_empty discards a zero-count record.
    drop_empty = 1;
    push_rec(4'd0, BUF_W'($urandom()));
    chk("dropempty_lvl", 64'(level), 64'd0);
    chk("dropempty_cnt", 64'(drop_cnt), 64'd0);
    drop_empty = 0;

    // Overfill: 18 records into 16 slots with no reads.
    rd_ready = 0;
    for (int i = 0; i < 18; i++) push_rec(4'($urandom_range(1, 15)), BUF_W'($urandom()));
    chk("full_lvl", 64'(level), 64'd16);
    chk("full_ovf", 64'(overflow), 64'd1);
    chk("full_drop", 64'(drop_cnt), 64'd2);
    rd_ready = 1;
    push_rec(4'($urandom_range(0, 15)), BUF_W'($urandom()));
    chk("pushpop_lvl", 64'(level), 64'd16);
    chk("pushpop_drop", 64'(drop_cnt), 64'd2);

    // Random traffic while running.
    for (int i = 0; i < 300; i++) begin
      dct_valid  = 1'($urandom_range(0, 1));
      dct_count  = 4'($urandom_range(0, 15));
      dct_buffer = BUF_W'($urandom());
      drop_empty = ($urandom_range(0, 3) == 0);
      rd_ready   = ($urandom_range(0, 2) != 0);
      step();
    end
    dct_valid = 0; drop_empty = 0;
    drain(40);

    // Reset in DRAIN with 7 records held.
    rd_ready = 0;
    for (int i = 0; i < 6; i++) push_rec(4'($urandom_range(1, 15)), BUF_W'($urandom()));
    test_ending = 1;
    push_rec(4'($urandom_range(1, 15)), BUF_W'($urandom()));
    test_ending = 0;
    chk("pre_rst_lvl", 64'(level), 64'd7);
    chk("pre_rst_state", 64'(state_dbg), 64'(ST_DRAIN));
    reset = 1;
    step();
    reset = 0;
    chk("rst_lvl", 64'(level), 64'd0);
    chk("rst_valid", 64'(rd_valid), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_state2", 64'(state_dbg), 64'(ST_IDLE));

    // Record still taken on the RUN->DRAIN edge; later ones ignored.
    enable = 1;
    step();
    enable = 0;
    for (int i = 0; i < 4; i++) push_rec(4'($urandom_range(0, 15)), BUF_W'($urandom()));
    test_ending = 1;
    push_rec(4'($urandom_range(1, 15)), BUF_W'($urandom()));
    test_ending = 0;
    push_rec(4'($urandom_range(1, 15)), BUF_W'($urandom()));
    push_rec(4'($urandom_range(1, 15)), BUF_W'($urandom()));
    chk("drain_lvl5", 64'(level), 64'd5);
    chk("drain_notdone", 64'(done), 64'd0);

    // End of test, then drain until done.
    test_has_ended = 1; rd_ready = 1;
    step();
    test_has_ended = 0;
    for (int k = 0; k < 30 && !done; k++) step();
    chk("done_reached", 64'(done), 64'd1);
    chk("done_lvl", 64'(level), 64'd0);
    push_rec(4'($urandom_range(1, 15)), BUF_W'($urandom()));
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
